// File: rtl/share_unmasker.sv
// Recombines SHARES Boolean shares of a secret into one value by XOR.
// Frames start with an in_first beat; framing violations pulse out_err and are counted.
module share_unmasker #(
    parameter int WIDTH  = 8,
    parameter int SHARES = 3
) (
    input  logic             C,
    input  logic             R,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic [7:0]       err_cnt
);

    localparam int CW = $clog2(SHARES + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(SHARES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [7:0]       errCnt_q, errCnt_d;
    logic             accept;
    logic             errEvent;

    // Handshake signals are decoded from the registered state only.
    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge C) begin
        if (R) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            errCnt_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            errCnt_q <= errCnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        errEvent = 1'b0;
        errCnt_d = errCnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_first) begin
                        acc_d   = in_data;
                        cnt_d   = CW'(1);
                        state_d = ACCUM;
                    end else begin
                        errEvent = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (in_first) begin
                        // A new frame start abandons the partial frame and restarts it.
                        acc_d    = in_data;
                        cnt_d    = CW'(1);
                        errEvent = 1'b1;
                    end else begin
                        acc_d = acc_q ^ in_data;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == LAST_CNT) begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        err_d = errEvent;
        if (errEvent && (errCnt_q != 8'hFF)) begin
            errCnt_d = errCnt_q + 8'h01;
        end
    end

    // The accumulator is masked so partial frames never reach the output.
    assign out_data = (state_q == HOLD) ? acc_q : '0;
    assign out_err  = err_q;
    assign err_cnt  = errCnt_q;

endmodule

// File: tb/tb_share_unmasker.sv
// Directed bench for share_unmasker (WIDTH=8, SHARES=3) with an output scoreboard.
module tb_share_unmasker;

    logic       C;
    logic       R;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_first;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_err;
    logic [7:0] err_cnt;

    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] sbQueue[$];
    logic [7:0] sbExpected;

    share_unmasker #(
        .WIDTH (8),
        .SHARES(3)
    ) dut (
        .C        (C),
        .R        (R),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_first (in_first),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_err  (out_err),
        .err_cnt  (err_cnt)
    );

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one beat for exactly one rising edge, then sample 1 time unit later.
    task automatic applyStimulus(input logic [7:0] data, input logic first);
        in_valid = 1'b1;
        in_data  = data;
        in_first = first;
        @(posedge C);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic applyReset();
        R = 1'b1;
        repeat (2) @(posedge C);
        #1;
        R = 1'b0;
    endtask

    task automatic stepCycle();
        @(posedge C);
        #1;
    endtask

    // Output transfers are scored at the falling edge before the edge that completes them.
    always @(negedge C) begin
        if (!R && out_valid && out_ready) begin
            if (sbQueue.size() == 0) begin
                compared++;
                mismatched++;
                $error("[TB] FAIL sb_out: observed=%0h expected=none (no frame queued)", out_data);
            end else begin
                sbExpected = sbQueue.pop_front();
                checkOutput("sb_out", out_data, sbExpected);
            end
        end
    end

    initial begin
        R         = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_first  = 1'b0;
        out_ready = 1'b1;

        applyReset();
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 8'h00);
        checkOutput("rst_out_err", out_err, 0);
        checkOutput("rst_err_cnt", err_cnt, 8'h00);

        $display("[TB] basic frame, out_ready=1");
        sbQueue.push_back(8'h69);
        applyStimulus(8'h5A, 1'b1);
        checkOutput("f1_partial_valid", out_valid, 0);
        checkOutput("f1_partial_data", out_data, 8'h00);
        applyStimulus(8'h3C, 1'b0);
        checkOutput("f1_partial_data2", out_data, 8'h00);
        applyStimulus(8'h0F, 1'b0);
        checkOutput("f1_valid", out_valid, 1);
        checkOutput("f1_data", out_data, 8'h69);
        checkOutput("f1_in_ready", in_ready, 0);
        checkOutput("f1_err", out_err, 0);
        stepCycle();
        checkOutput("f1_valid_drop", out_valid, 0);
        checkOutput("f1_in_ready_back", in_ready, 1);
        checkOutput("f1_err_cnt", err_cnt, 8'h00);

        $display("[TB] backpressure hold");
        out_ready = 1'b0;
        sbQueue.push_back(8'h69);
        applyStimulus(8'h5A, 1'b1);
        applyStimulus(8'h3C, 1'b0);
        applyStimulus(8'h0F, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid", out_valid, 1);
            checkOutput("bp_data", out_data, 8'h69);
            checkOutput("bp_in_ready", in_ready, 0);
            stepCycle();
        end
        out_ready = 1'b1;
        stepCycle();
        checkOutput("bp_done_valid", out_valid, 0);
        checkOutput("bp_done_in_ready", in_ready, 1);

        $display("[TB] stray beat in IDLE then frame");
        applyStimulus(8'h11, 1'b0);
        checkOutput("stray_err", out_err, 1);
        checkOutput("stray_err_cnt", err_cnt, 8'h01);
        checkOutput("stray_valid", out_valid, 0);
        sbQueue.push_back(8'hFF);
        applyStimulus(8'hAA, 1'b1);
        checkOutput("stray_err_single", out_err, 0);
        applyStimulus(8'h55, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("f3_valid", out_valid, 1);
        checkOutput("f3_data", out_data, 8'hFF);
        stepCycle();
        checkOutput("f3_err_cnt", err_cnt, 8'h01);

        $display("[TB] restart inside a frame");
        applyReset();
        sbQueue.push_back(8'hE0);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h80, 1'b1);
        checkOutput("restart_err", out_err, 1);
        checkOutput("restart_err_cnt", err_cnt, 8'h01);
        checkOutput("restart_valid", out_valid, 0);
        applyStimulus(8'h40, 1'b0);
        checkOutput("restart_err_single", out_err, 0);
        applyStimulus(8'h20, 1'b0);
        checkOutput("restart_out_valid", out_valid, 1);
        checkOutput("restart_data", out_data, 8'hE0);
        stepCycle();
        checkOutput("restart_err_cnt_final", err_cnt, 8'h01);

        $display("[TB] reset aborts a partial frame");
        applyReset();
        applyStimulus(8'h33, 1'b1);
        applyStimulus(8'h44, 1'b0);
        R = 1'b1;
        stepCycle();
        R = 1'b0;
        checkOutput("abort_valid", out_valid, 0);
        checkOutput("abort_err", out_err, 0);
        checkOutput("abort_in_ready", in_ready, 1);
        sbQueue.push_back(8'hFF);
        applyStimulus(8'h0F, 1'b1);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("abort_next_valid", out_valid, 1);
        checkOutput("abort_next_data", out_data, 8'hFF);
        checkOutput("abort_err_cnt", err_cnt, 8'h00);
        stepCycle();

        $display("[TB] reset drops a held value");
        out_ready = 1'b0;
        applyStimulus(8'h12, 1'b1);
        applyStimulus(8'h34, 1'b0);
        applyStimulus(8'h56, 1'b0);
        checkOutput("holdrst_valid_pre", out_valid, 1);
        R = 1'b1;
        stepCycle();
        R = 1'b0;
        checkOutput("holdrst_valid", out_valid, 0);
        checkOutput("holdrst_data", out_data, 8'h00);
        checkOutput("holdrst_err", out_err, 0);
        checkOutput("holdrst_in_ready", in_ready, 1);
        out_ready = 1'b1;

        $display("[TB] error counter saturation");
        applyReset();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(8'(i), 1'b0);
            checkOutput("sat_err", out_err, 1);
            checkOutput("sat_err_cnt", err_cnt, (i + 1 > 255) ? 64'd255 : 64'(i + 1));
        end
        stepCycle();
        checkOutput("sat_err_idle", out_err, 0);
        checkOutput("sat_err_cnt_final", err_cnt, 8'hFF);

        stepCycle();
        checkOutput("sb_pending", sbQueue.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
